// File: rtl/fix_pkg.sv
// Shared fixed-point helpers for the conv/pool datapath blocks.
// Holds lane/stage counts, width helpers and the saturating narrow.
package fix_pkg;

  localparam int NUM_LANES   = 25;
  localparam int TREE_STAGES = 5;
  localparam int TREE_GROWTH = 5;   // ceil(log2(NUM_LANES)) growth bits
  localparam int SAT_MAX_W   = 64;

  typedef struct packed {
    logic [SAT_MAX_W-1:0] value;
    logic                 clip;
  } sat_t;

  function automatic int tree_width(input int width);
    return width + TREE_GROWTH;
  endfunction

  function automatic int acc_width(input int width, input int guard);
    return tree_width(width) + guard;
  endfunction

  // Number of live operands after `level` pairwise reductions of NUM_LANES.
  function automatic int lanes_at(input int level);
    int n;
    n = NUM_LANES;
    for (int i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic sat_t sat_fix(input logic signed [SAT_MAX_W-1:0] value,
                                   input int width);
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    sat_t r;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.clip = 1'b1;
    if (value > hi)      r.value = hi;
    else if (value < lo) r.value = lo;
    else begin
      r.value = value;
      r.clip  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/vec25_add_tree.sv
// Five-stage registered pairwise adder tree (25->13->7->4->2->1)
// with valid/first/last/bias carried alongside on a matching shift register.
module vec25_add_tree
  import fix_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int TW    = tree_width(WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic [WIDTH*NUM_LANES-1:0]     inP_25P,
  input  logic [WIDTH-1:0]               bias,
  output logic signed [TW-1:0]           sum,
  output logic                           sum_valid,
  output logic                           sum_first,
  output logic                           sum_last,
  output logic [WIDTH-1:0]               sum_bias
);

  for (genvar s = 0; s < TREE_STAGES; s++) begin : g_stage
    localparam int N_IN  = lanes_at(s);
    localparam int N_OUT = lanes_at(s + 1);

    logic signed [TW-1:0] d [N_IN];

    for (genvar k = 0; k < N_IN; k++) begin : g_in
      if (s == 0) begin : g_lane
        assign d[k] = TW'($signed(inP_25P[WIDTH*k +: WIDTH]));
      end else begin : g_prev
        assign d[k] = g_stage[s-1].g_out[k].r;
      end
    end

    // An odd leftover operand is simply re-registered so every path has equal depth.
    for (genvar k = 0; k < N_OUT; k++) begin : g_out
      logic signed [TW-1:0] r;
      if (2*k + 1 < N_IN) begin : g_add
        always_ff @(posedge clk) r <= d[2*k] + d[2*k+1];
      end else begin : g_pass
        always_ff @(posedge clk) r <= d[2*k];
      end
    end
  end

  assign sum = g_stage[TREE_STAGES-1].g_out[0].r;

  logic [TREE_STAGES-1:0] v_pipe;
  logic [TREE_STAGES-1:0] f_pipe;
  logic [TREE_STAGES-1:0] l_pipe;
  logic [WIDTH-1:0]       b_pipe [TREE_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_pipe <= '0;
      f_pipe <= '0;
      l_pipe <= '0;
    end else begin
      v_pipe <= {v_pipe[TREE_STAGES-2:0], in_valid};
      f_pipe <= {f_pipe[TREE_STAGES-2:0], in_valid & in_first};
      l_pipe <= {l_pipe[TREE_STAGES-2:0], in_valid & in_last};
    end
  end

  always_ff @(posedge clk) begin
    b_pipe[0] <= bias;
    for (int i = 1; i < TREE_STAGES; i++) b_pipe[i] <= b_pipe[i-1];
  end

  assign sum_valid = v_pipe[TREE_STAGES-1];
  assign sum_first = f_pipe[TREE_STAGES-1];
  assign sum_last  = l_pipe[TREE_STAGES-1];
  assign sum_bias  = b_pipe[TREE_STAGES-1];

endmodule

// File: rtl/vec25_acc_reduce.sv
// Reduces a 25-product beat to one sum, accumulates beats over a channel
// group with bias, and emits one saturated result per group.
module vec25_acc_reduce
  import fix_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int POINT_WIDTH = 8,
  parameter int ACC_GUARD   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [WIDTH*NUM_LANES-1:0] inP_25P,
  input  logic [WIDTH-1:0]           bias,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_sum,
  output logic                       out_sat
);

  localparam int TW = tree_width(WIDTH);
  localparam int AW = acc_width(WIDTH, ACC_GUARD);

  // Inputs, bias and result share one Q format, so the point is never moved.
  if (POINT_WIDTH < 0 || POINT_WIDTH >= WIDTH) begin : g_bad_point
    $error("vec25_acc_reduce: POINT_WIDTH must lie in [0, WIDTH)");
  end

  logic signed [TW-1:0] tree_sum;
  logic                 tree_valid;
  logic                 tree_first;
  logic                 tree_last;
  logic [WIDTH-1:0]     tree_bias;

  vec25_add_tree #(.WIDTH(WIDTH)) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .inP_25P   (inP_25P),
    .bias      (bias),
    .sum       (tree_sum),
    .sum_valid (tree_valid),
    .sum_first (tree_first),
    .sum_last  (tree_last),
    .sum_bias  (tree_bias)
  );

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] tree_ext;
  logic signed [AW-1:0] bias_ext;
  sat_t                 sat_res;
  logic                 unused_sat_hi;

  assign tree_ext = AW'(tree_sum);
  assign bias_ext = AW'($signed(tree_bias));

  always_comb begin
    acc_next = acc + tree_ext;
    if (tree_first) acc_next = tree_ext + bias_ext;
  end

  assign sat_res       = sat_fix(SAT_MAX_W'(acc_next), WIDTH);
  assign unused_sat_hi = ^sat_res.value[SAT_MAX_W-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (tree_valid) begin
        acc <= acc_next;
        if (tree_last) begin
          out_valid <= 1'b1;
          out_sum   <= sat_res.value[WIDTH-1:0];
          out_sat   <= sat_res.clip;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec25_acc_reduce.sv
// Directed self-checking bench for vec25_acc_reduce: table of single-beat
// groups plus hand-written multi-beat, back-to-back and reset sequences.
module tb_vec25_acc_reduce;

  localparam int W  = 16;
  localparam int NL = 25;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_first = 1'b0;
  logic            in_last  = 1'b0;
  logic [W*NL-1:0] inP_25P  = '0;
  logic [W-1:0]    bias     = '0;
  logic            out_valid;
  logic [W-1:0]    out_sum;
  logic            out_sat;

  vec25_acc_reduce #(.WIDTH(W), .POINT_WIDTH(8), .ACC_GUARD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .inP_25P   (inP_25P),
    .bias      (bias),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         stamp;
    logic [W-1:0] sum;
    logic       sat;
  } pulse_t;
  pulse_t q[$];

  always @(negedge clk) begin
    if (out_valid) q.push_back('{stamp: cyc, sum: out_sum, sat: out_sat});
  end

  typedef struct {
    string        name;
    logic [W*NL-1:0] data;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_sat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int last_sample = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W*NL-1:0] splat(input logic [W-1:0] v);
    logic [W*NL-1:0] d;
    for (int k = 0; k < NL; k++) d[W*k +: W] = v;
    return d;
  endfunction

  task automatic beat(input logic [W*NL-1:0] d, input logic [W-1:0] b,
                      input logic f, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    inP_25P  = d;
    bias     = b;
    last_sample = cyc + 1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_pulse(input string nm, input int stamp,
                              input logic [W-1:0] s, input logic sat);
    pulse_t p;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s out_valid pulses got 0 expected 1", nm);
    end else begin
      p = q.pop_front();
      chk({nm, "_cycle"}, p.stamp, stamp);
      chk({nm, "_sum"},   p.sum,   s);
      chk({nm, "_sat"},   p.sat,   sat);
    end
  endtask

  task automatic expect_empty(input string nm);
    chk({nm, "_extra_pulses"}, q.size(), 0);
    q.delete();
  endtask

  vec_t vecs[8];

  initial begin
    logic [W*NL-1:0] ramp, mixed;
    int s0, c;

    for (int k = 0; k < NL; k++) ramp[W*k +: W] = W'(k);
    for (int k = 0; k < NL; k++) mixed[W*k +: W] = (k < 12) ? 16'h0100 : 16'hFF00;

    vecs[0] = '{"all_one",   splat(16'h0100), 16'h0000, 16'h1900, 1'b0};
    vecs[1] = '{"ramp",      ramp,            16'h0080, 16'h01AC, 1'b0};
    vecs[2] = '{"pos_sat",   splat(16'h7FFF), 16'h0000, 16'h7FFF, 1'b1};
    vecs[3] = '{"neg_sat",   splat(16'h8000), 16'h0000, 16'h8000, 1'b1};
    vecs[4] = '{"mixed",     mixed,           16'h0000, 16'hFF00, 1'b0};
    vecs[5] = '{"bias_max",  splat(16'h0000), 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[6] = '{"exact_max", splat(16'h051E), 16'h0011, 16'h7FFF, 1'b0};
    vecs[7] = '{"one_over",  splat(16'h051E), 16'h0012, 16'h7FFF, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sum",   out_sum,   0);
    chk("reset_out_sat",   out_sat,   0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();

    for (int i = 0; i < 8; i++) begin
      beat(vecs[i].data, vecs[i].b, 1'b1, 1'b1);
      idle();
      repeat (8) @(negedge clk);
      expect_pulse(vecs[i].name, last_sample + 5, vecs[i].exp_sum, vecs[i].exp_sat);
      expect_empty(vecs[i].name);
    end
    chk("hold_sum_after_pulse", out_sum, 16'h7FFF);

    // Three-beat group; later bias values must be ignored.
    beat(splat(16'h0100), 16'h0100, 1'b1, 1'b0);
    beat(splat(16'h0100), 16'h7777, 1'b0, 1'b0);
    beat(splat(16'h0100), 16'h1234, 1'b0, 1'b1);
    idle();
    repeat (8) @(negedge clk);
    expect_pulse("three_beat", last_sample + 5, 16'h4C00, 1'b0);
    expect_empty("three_beat");

    // Five back-to-back single-beat groups.
    for (int i = 0; i < 5; i++) begin
      beat(splat(W'(i + 1)), 16'h0000, 1'b1, 1'b1);
      if (i == 0) s0 = last_sample;
    end
    idle();
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++)
      expect_pulse($sformatf("b2b%0d", i), s0 + 5 + i, W'(25 * (i + 1)), 1'b0);
    expect_empty("b2b");

    // Beat without in_first after a finished group adds onto the stale acc.
    beat(splat(16'h0010), 16'h0000, 1'b1, 1'b1);
    idle();
    repeat (8) @(negedge clk);
    expect_pulse("stale_base", last_sample + 5, 16'h0190, 1'b0);
    beat(splat(16'h0004), 16'h1234, 1'b0, 1'b1);
    idle();
    repeat (8) @(negedge clk);
    expect_pulse("stale_add", last_sample + 5, 16'h01F4, 1'b0);
    expect_empty("stale");

    // in_first mid-group restarts the group.
    beat(splat(16'h0100), 16'h0100, 1'b1, 1'b0);
    beat(splat(16'h0002), 16'h0010, 1'b1, 1'b1);
    idle();
    repeat (8) @(negedge clk);
    expect_pulse("restart", last_sample + 5, 16'h0042, 1'b0);
    expect_empty("restart");

    // Reset three cycles after a last beat drops the group.
    beat(splat(16'h0100), 16'h0000, 1'b1, 1'b1);
    c = last_sample;
    idle();
    for (int n = 0; n < 10 && cyc < c + 2; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    expect_empty("reset_drop");
    chk("reset_drop_sum", out_sum, 0);
    chk("reset_drop_sat", out_sat, 0);
    beat(splat(16'h0003), 16'h0005, 1'b1, 1'b1);
    idle();
    repeat (8) @(negedge clk);
    expect_pulse("after_reset", last_sample + 5, 16'h0050, 1'b0);
    expect_empty("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec25_acc_reduce.md
Name: vec25_acc_reduce

Overview:
- Consumer-side counterpart to the 25-lane fixed-point multiplier vector. It takes the packed 25-product bus, reduces it to one sum through a pipelined adder tree, and accumulates successive beats over a channel group with a bias.
- It emits one saturated fixed-point result per group, which is a conv-layer output pixel.
- It sits directly after the multiplier vector in the 5x5 convolution datapath.

Parameters:
- WIDTH, 16, total signed fixed-point width of each element and of the result.
- POINT_WIDTH, 8, fractional bits. Inputs, bias and result share this format, so no realignment is done.
- ACC_GUARD, 8, extra accumulator bits above the tree width. Supports up to 2^ACC_GUARD beats per group without wrap.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  beat present on inP_25P this cycle.
- in_first  in  1  first beat of a group; loads the accumulator and samples bias. Qualified by in_valid.
- in_last  in  1  last beat of a group; triggers output. Qualified by in_valid.
- inP_25P  in  WIDTH*25  packed products; element k at bits [WIDTH*k +: WIDTH], element 0 at LSB.
- bias  in  WIDTH  group bias, sampled only on a valid first beat.
- out_valid  out  1  one-cycle pulse; out_sum and out_sat are valid.
- out_sum  out  WIDTH  saturated group result.
- out_sat  out  1  1 when out_sum was clipped.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Flow control: no backpressure. Accepts one beat every cycle, fully pipelined.
- Reset values: out_valid=0, out_sum=0, out_sat=0. Valid and flag pipeline cleared, accumulator=0.
- Reset mid-operation: all in-flight beats and any partial group are dropped, with no out_valid. The first valid beat after reset must carry in_first.
- Arithmetic: signed two's complement throughout. Each element is sign-extended to TW=WIDTH+5 bits.
- Tree: 5 registered stages, 25 -> 13 -> 7 -> 4 -> 2 -> 1. The odd leftover at each stage passes through registered (equivalent to a zero pad). No overflow inside TW.
- Sideband: valid, first, last and the sampled bias are pipelined alongside the tree, 5 stages.
- Accumulator (AW=TW+ACC_GUARD), at stage 6 on a valid tree result:
  - first=1: acc <= tree_sum + sext(bias).
  - first=0: acc <= acc + tree_sum.
  - first=1 and last=1 together is legal: a single-beat group.
- Accumulator overflow: more than 2^ACC_GUARD beats in a group wraps modulo 2^AW. No detection.
- Output register, same cycle acc is updated, when last=1:
  - out_sum <= sat(acc_next), out_valid <= 1.
  - Otherwise out_valid <= 0, and out_sum/out_sat hold their previous values.
- Saturation: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. out_sat=1 iff clamped.
- Latency: a valid beat with in_last at cycle t gives out_valid at t+6 for that group.
- Back-to-back groups: in_last at t followed by in_first at t+1 gives independent results. Outputs on consecutive cycles are allowed.
- Protocol errors:
  - A beat without in_first after in_last accumulates onto the stale acc.
  - in_first mid-group restarts the group.
  - Both are defined, not flagged.

Decomposition:
- Shared package fix_pkg:
  - NUM_LANES=25 and TREE_STAGES=5.
  - TW/AW width constants.
  - Saturating narrow function sat_fix(value, WIDTH) returning the clipped value and clip flag; shared with other conv/pool blocks.
- One sub-module, vec25_add_tree: the 5-stage registered reduction with the sideband shift register.
- The top holds the accumulator, the output register and the saturation.

Test Plan (WIDTH=16, POINT_WIDTH=8, 1.0=0x0100):
1. All 25 elements 0x0100, first=last=1, bias=0 -> out_valid exactly 6 cycles later, out_sum=0x1900, out_sat=0.
2. Element k = k (raw), first=last=1, bias=0x0080 -> out_sum=300+128=0x01AC.
3. 3-beat group on consecutive cycles, each all 0x0100, bias=0x0100 on the first beat, bias changed on beats 2-3 -> single out_valid 6 cycles after the last beat, out_sum=0x4C00. Changed bias is ignored.
4. Saturation:
   - All 0x7FFF, single beat -> out_sum=0x7FFF, out_sat=1.
   - All 0x8000 -> out_sum=0x8000, out_sat=1.
   - Mixed +/-, summing to -1.0 -> out_sum=0xFF00, out_sat=0.
5. Five single-beat groups on five consecutive cycles with distinct values -> five consecutive out_valid pulses with matching sums in order.
6. rst asserted 3 cycles after a last beat -> no out_valid for that group, outputs read 0. Next clean group is correct at +6.
